// File: rtl/xbee_tx_pkg.sv
// Shared definitions for the XBee transmit-side byte scheduler:
// FSM state encoding and default sizing.
package xbee_tx_pkg;

  localparam int N_DEF       = 4;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 50000;
  localparam int TO_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N, returned both one-hot and as an index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [PW-1:0] win_idx,
  output logic          win_valid
);

  always_comb begin
    logic [PW-1:0] idx;
    // NOTE: every output gets a default first so no path leaves a latch.
    win_oh    = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!win_valid && req[idx]) begin
        win_valid   = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin owner of the shared UART serializer with a completion timeout.
// Define BURST_LOCK_EN to keep the grant across a multi-byte frame (HOLD state).
module tx_arbiter
  import xbee_tx_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] data,
  input  logic [N-1:0]    last,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    grant,
  output logic            tx_start,
  output logic [DW-1:0]   tx_data,
  input  logic            tx_done,
  output logic            busy,
  output logic            err
);

  localparam int PW = $clog2(N);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [TO_W-1:0] cnt;

  logic [N-1:0]    win_oh;
  logic [PW-1:0]   win_idx;
  logic            win_valid;
  logic [DW-1:0]   win_byte;
  logic [PW-1:0]   next_ptr;
  logic            timed_out;
  logic            rel_done;
  logic            abort;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req       (req),
    .ptr       (ptr),
    .win_oh    (win_oh),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  assign next_ptr  = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
  assign timed_out = (cnt == TO_W'(TIMEOUT - 1));

`ifdef BURST_LOCK_EN
  logic          last_q;
  logic [DW-1:0] own_byte;
  logic          own_last;
  logic          own_req;
  logic          win_last;

  always_comb begin
    win_byte = '0;
    win_last = 1'b0;
    own_byte = '0;
    own_last = 1'b0;
    own_req  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == PW'(i)) begin
        win_byte = data[i*DW +: DW];
        win_last = last[i];
      end
      if (owner == PW'(i)) begin
        own_byte = data[i*DW +: DW];
        own_last = last[i];
        own_req  = req[i];
      end
    end
  end

  // A byte that is not the end of its frame keeps the grant instead of releasing.
  assign rel_done = (state == WAIT) && tx_done && last_q;
  assign abort    = ((state == WAIT) && !tx_done && timed_out) ||
                    ((state == HOLD) && !own_req && timed_out);
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N; i++)
      if (win_idx == PW'(i)) win_byte = data[i*DW +: DW];
  end

  assign rel_done = (state == WAIT) && tx_done;
  assign abort    = (state == WAIT) && !tx_done && timed_out;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: synchronous reset clears every register; the serializer itself is left running.
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      grant    <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef BURST_LOCK_EN
      last_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; pulses default low each cycle.
      ack      <= '0;
      tx_start <= 1'b0;
      err      <= 1'b0;
      if (rel_done || abort) begin
        err   <= abort;
        grant <= '0;
        busy  <= 1'b0;
        ptr   <= next_ptr;
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: if (win_valid) begin
            grant    <= win_oh;
            owner    <= win_idx;
            tx_data  <= win_byte;
            ack      <= win_oh;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
`ifdef BURST_LOCK_EN
            last_q   <= win_last;
`endif
            state    <= START;
          end
          START: begin
            cnt   <= cnt + 1'b1;
            state <= WAIT;
          end
          WAIT: begin
`ifdef BURST_LOCK_EN
            if (tx_done) begin
              cnt   <= '0;
              state <= HOLD;
            end else
`endif
            cnt <= cnt + 1'b1;
          end
`ifdef BURST_LOCK_EN
          HOLD: if (own_req) begin
            tx_data  <= own_byte;
            last_q   <= own_last;
            ack      <= grant;
            tx_start <= 1'b1;
            cnt      <= '0;
            state    <= START;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: randomized requesters and serializer
// delays checked against a queue-free round-robin reference model.
`timescale 1ns/1ps
module tb_tx_arbiter;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 100;
  localparam int TO_W    = 16;
`ifdef BURST_LOCK_EN
  localparam bit BURST = 1'b1;
  localparam int EXP_ORDER [4] = '{1, 1, 1, 3};
`else
  localparam bit BURST = 1'b0;
  localparam int EXP_ORDER [4] = '{1, 3, 1, 1};
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]    last = '1;
  logic            tx_done = 1'b0;
  logic [N-1:0]    ack, grant;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            busy, err;

  int vectors     = 0;
  int miscompares = 0;
  int ptr_m       = 0;   // model round-robin pointer
  int hold_owner  = -1;  // model frame lock owner, -1 when free

  tx_arbiter #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .last     (last),
    .ack      (ack),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int winner(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  function automatic int next_exp();
    return (hold_owner >= 0) ? hold_owner : winner(req);
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    ptr_m = 0;
    hold_owner = -1;
  endtask

  // One byte through the arbiter: accept, serializer busy for `delay` cycles, done.
  task automatic serve(input int exp, input int delay, input bit drop,
                       input logic [DW-1:0] nxt, input bit nxt_last, input string tag);
    logic [DW-1:0] b;
    bit hold;
    b = data[exp*DW +: DW];
    hold = BURST && !last[exp];
    tick;
    vectors++;
    if ({ack, grant, tx_start, tx_data, busy, err} !== {oh(exp), oh(exp), 1'b1, b, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL %s accept: ack=%b grant=%b start=%b data=%h busy=%b err=%b, expected ack=grant=%b start=1 data=%h busy=1 err=0",
               tag, ack, grant, tx_start, tx_data, busy, err, oh(exp), b);
    end
    if (drop) req[exp] = 1'b0;
    else begin
      data[exp*DW +: DW] = nxt;
      last[exp] = nxt_last;
    end
    tick;
    vectors++;
    if ({ack, tx_start, grant, tx_data, busy} !== {{N{1'b0}}, 1'b0, oh(exp), b, 1'b1}) begin
      miscompares++;
      $display("FAIL %s wait: ack=%b start=%b grant=%b data=%h busy=%b, expected ack=0 start=0 grant=%b data=%h busy=1",
               tag, ack, tx_start, grant, tx_data, busy, oh(exp), b);
    end
    repeat (delay - 1) tick;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    vectors++;
    if (hold) begin
      if ({grant, busy, err} !== {oh(exp), 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL %s hold: grant=%b busy=%b err=%b, expected grant=%b busy=1 err=0",
                 tag, grant, busy, err, oh(exp));
      end
      hold_owner = exp;
    end else begin
      if ({grant, busy, err} !== {{N{1'b0}}, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL %s release: grant=%b busy=%b err=%b, expected all 0", tag, grant, busy, err);
      end
      hold_owner = -1;
      ptr_m = (exp + 1) % N;
    end
  endtask

  task automatic test_reset;
    req = '0;
    tick;
    tick;
    vectors++;
    if ({ack, grant, tx_start, tx_data, busy, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_held: ack=%b grant=%b start=%b data=%h busy=%b err=%b, expected all 0",
               ack, grant, tx_start, tx_data, busy, err);
    end
    reset = 1'b0;
    tick;
    vectors++;
    if ({ack, grant, tx_start, busy, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: ack=%b grant=%b start=%b busy=%b err=%b, expected all 0",
               ack, grant, tx_start, busy, err);
    end
  endtask

  task automatic test_single;
    data[0 +: DW] = 8'h41;
    req = 4'b0001;
    serve(0, 20, 1'b1, '0, 1'b1, "single");
  endtask

  task automatic test_reset_mid;
    req = 4'b0010;
    tick;
    req = '0;
    repeat (3) tick;
    reset = 1'b1;
    tick;
    vectors++;
    if ({ack, grant, tx_start, tx_data, busy, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: ack=%b grant=%b start=%b data=%h busy=%b err=%b, expected all 0",
               ack, grant, tx_start, tx_data, busy, err);
    end
    reset = 1'b0;
    ptr_m = 0;
    hold_owner = -1;
    data[0 +: DW] = 8'h5A;
    req = 4'b1011;
    serve(winner(req), 4, 1'b1, '0, 1'b1, "ptr_after_reset");
    data[2*DW +: DW] = 8'h7E;
    req = 4'b0100;
    serve(winner(req), 6, 1'b1, '0, 1'b1, "req2_after_reset");
  endtask

  task automatic test_round_robin;
    do_reset;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'($urandom);
    req = '1;
    for (int s = 0; s < 5; s++)
      serve(next_exp(), $urandom_range(1, 12), 1'b0, DW'($urandom), 1'b1, "round_robin");
    req = '0;
  endtask

  task automatic test_timeout;
    int w, t;
    req = '1;
    w = winner(req);
    tick;
    req = '0;
    vectors++;
    if ({ack, tx_start} !== {oh(w), 1'b1}) begin
      miscompares++;
      $display("FAIL timeout_start: ack=%b start=%b, expected ack=%b start=1", ack, tx_start, oh(w));
    end
    t = 0;
    for (int k = 1; k <= 2 * TIMEOUT && t == 0; k++) begin
      tick;
      if (err === 1'b1) t = k;
    end
    vectors++;
    if (t != TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout_latency: err after %0d cycles, expected %0d", t, TIMEOUT);
    end
    vectors++;
    if ({grant, busy} !== '0) begin
      miscompares++;
      $display("FAIL timeout_release: grant=%b busy=%b, expected 0", grant, busy);
    end
    tick;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err_once: err=%b, expected 0", err);
    end
    ptr_m = (w + 1) % N;
    req = '1;
    serve(winner(req), 3, 1'b1, '0, 1'b1, "after_timeout");
    req = '0;
  endtask

  task automatic test_coincident;
    int w;
    req = '1;
    w = winner(req);
    tick;
    req = '0;
    vectors++;
    if ({ack, tx_start} !== {oh(w), 1'b1}) begin
      miscompares++;
      $display("FAIL coincident_start: ack=%b start=%b, expected ack=%b start=1", ack, tx_start, oh(w));
    end
    repeat (TIMEOUT - 1) tick;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    vectors++;
    if ({err, grant, busy} !== '0) begin
      miscompares++;
      $display("FAIL coincident_release: err=%b grant=%b busy=%b, expected all 0", err, grant, busy);
    end
    tick;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL coincident_err: err=%b, expected 0", err);
    end
    ptr_m = (w + 1) % N;
  endtask

  task automatic test_random;
    logic [N-1:0] r;
    last = '1;
    for (int it = 0; it < 25; it++) begin
      r = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'($urandom);
      req = r;
      if (r == '0) begin
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        vectors++;
        if ({ack, grant, tx_start, busy, err} !== '0) begin
          miscompares++;
          $display("FAIL random_idle: ack=%b grant=%b start=%b busy=%b err=%b, expected all 0",
                   ack, grant, tx_start, busy, err);
        end
      end else begin
        serve(next_exp(), $urandom_range(1, 15), 1'b1, '0, 1'b1, "random");
      end
    end
    req = '0;
  endtask

  task automatic test_burst;
    int order [$];
    int e, nb;
    do_reset;
    req = 4'b1010;
    last = 4'b1000;
    data[1*DW +: DW] = 8'hA1;
    data[3*DW +: DW] = 8'hC3;
    nb = 0;
    for (int s = 0; s < 4; s++) begin
      e = next_exp();
      order.push_back(e);
      if (e == 1) begin
        nb++;
        serve(e, $urandom_range(2, 9), nb == 3, DW'(8'hA1 + nb), nb == 2, "burst");
      end else begin
        serve(e, $urandom_range(2, 9), 1'b1, '0, 1'b1, "burst_other");
      end
    end
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (order[s] != EXP_ORDER[s]) begin
        miscompares++;
        $display("FAIL burst_order[%0d]: served %0d, expected %0d", s, order[s], EXP_ORDER[s]);
      end
    end
    req = '0;
    last = '1;
  endtask

  initial begin
    test_reset;
    test_single;
    test_reset_mid;
    test_round_robin;
    test_timeout;
    test_coincident;
    test_random;
    test_burst;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
